// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the ALU arbiter slice.
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int DATA_W_D = 8;
  localparam int OP_W_D   = 4;
  localparam int RES_W_D  = 16;
  localparam int STAT_W   = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Walk the offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        grant = N_REQ'(1) << ((int'(ptr) + k) % N_REQ);
        idx   = IDX_W'((int'(ptr) + k) % N_REQ);
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one clocked ALU among N_REQ requesters, one operation in flight.
// Optional per-requester grant counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_D,
  parameter int OP_W    = OP_W_D,
  parameter int RES_W   = RES_W_D,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]        rsp_result,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_opcode,
  input  logic [RES_W-1:0]        alu_result,
  output logic                    busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);
  localparam int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  if (ALU_LAT < 1) begin : g_bad_lat
    $error("alu_arbiter: ALU_LAT must be at least 1");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("alu_arbiter: N_REQ must be in 2..8");
  end

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [LAT_W-1:0] lat_cnt;

  logic [N_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             gnt_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx_c),
    .any   (gnt_any)
  );

  // Gated by reset so no accept is advertised while the block is held in reset.
  assign req_ready = (state == IDLE && reset) ? gnt_oh : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      lat_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            alu_a      <= req_a[int'(gnt_idx_c)*DATA_W +: DATA_W];
            alu_b      <= req_b[int'(gnt_idx_c)*DATA_W +: DATA_W];
            alu_opcode <= req_op[int'(gnt_idx_c)*OP_W +: OP_W];
            gnt_idx    <= gnt_idx_c;
            rr_ptr     <= IDX_W'((int'(gnt_idx_c) + 1) % N_REQ);
            lat_cnt    <= LAT_W'(ALU_LAT);
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt == LAT_W'(1)) begin
            rsp_result <= alu_result;
            rsp_valid  <= N_REQ'(1) << gnt_idx;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready[gnt_idx]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else if (|(req_ready & req_valid)) begin
      if (cnt_q[gnt_idx_c] != {STAT_W{1'b1}})
        cnt_q[gnt_idx_c] <= cnt_q[gnt_idx_c] + STAT_W'(1);
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt_out
    assign grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif
endmodule
